// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame constants.
// Imported by uart_rx, uart_tx and their helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for an asynchronous input pin.
// Ports: clk, rst_n (sync, active-low), d (async in), q (synchronised out).
module sync2 #(
    parameter logic INIT = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= INIT;
            q    <= INIT;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit start validation and stop-bit check.
// Ports: clk, rst_n (sync, active-low), i_rx (async line, idle high),
//        o_data (last good byte), o_vld / o_err (1-cycle pulses), o_busy.
module uart_rx
    import uart_pkg::*;
#(
    parameter int FREQ = 50_000_000,
    parameter int RATE = 2_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_vld,
    output logic       o_err,
    output logic       o_busy
);

    localparam int DIV  = FREQ / RATE;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);
    localparam int IW   = $clog2(DATA_BITS);

    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [IW-1:0] LAST    = IW'(DATA_BITS - 1);

    generate
        if (DIV < 4) begin : g_div_check
            $error("uart_rx: FREQ/RATE must be at least 4");
        end
    endgenerate

    logic                 rx_s;
    state_t               state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] sh;

    sync2 #(.INIT(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (i_rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            sh     <= '0;
            o_data <= '0;
            o_vld  <= 1'b0;
            o_err  <= 1'b0;
            o_busy <= 1'b0;
        end else begin
            o_vld <= 1'b0;
            o_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state  <= START;
                        o_busy <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                            idx   <= '0;
                        end else begin
                            // Too short to be a start bit: drop it.
                            state  <= IDLE;
                            o_busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == DIV_M1) begin
                        cnt <= '0;
                        // LSB arrives first, so shift right from the MSB.
                        sh  <= {rx_s, sh[DATA_BITS-1:1]};
                        idx <= idx + 1'b1;
                        if (idx == LAST) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == DIV_M1) begin
                        cnt <= '0;
                        if (rx_s) begin
                            o_data <= sh;
                            o_vld  <= 1'b1;
                            state  <= IDLE;
                            o_busy <= 1'b0;
                        end else begin
                            o_err <= 1'b1;
                            state <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    // Line held low: wait for it to return idle.
                    if (rx_s) begin
                        cnt    <= '0;
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt    <= '0;
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx with an event-queue reference model.
// Drives serial frames and checks o_vld/o_err/o_data every cycle.
module tb_uart_rx;

    localparam int DIV = 25;
    localparam int LAT = 240;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_rx = 1'b1;
    logic [7:0] o_data;
    logic       o_vld;
    logic       o_err;
    logic       o_busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic rst_q = 1'b0;

    typedef struct {
        int         at;
        bit         err;
        logic [7:0] data;
    } ev_t;

    ev_t        evq[$];
    logic [7:0] model_data = 8'h00;

    int         vq[$];
    logic [7:0] dq[$];
    int         eq[$];
    int         busy_fall = -1;
    logic       prev_busy = 1'b0;

    uart_rx #(.FREQ(50_000_000), .RATE(2_000_000)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_rx   (i_rx),
        .o_data (o_data),
        .o_vld  (o_vld),
        .o_err  (o_err),
        .o_busy (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst_n;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: frames push expected pulses at start+LAT.
    always @(negedge clk) begin
        logic exp_vld;
        logic exp_err;
        ev_t  ev;
        if (cyc >= 1) begin
            exp_vld = 1'b0;
            exp_err = 1'b0;
            if (!rst_q) begin
                model_data = 8'h00;
            end else if (evq.size() > 0 && evq[0].at == cyc) begin
                ev = evq.pop_front();
                if (ev.err) begin
                    exp_err = 1'b1;
                end else begin
                    exp_vld = 1'b1;
                    model_data = ev.data;
                end
            end
            chk("vld", 32'(o_vld), 32'(exp_vld));
            chk("err", 32'(o_err), 32'(exp_err));
            chk("data", 32'(o_data), 32'(model_data));
            chk("vld_err_excl", 32'(o_vld & o_err), 32'd0);
            if (o_vld) begin
                vq.push_back(cyc);
                dq.push_back(o_data);
            end
            if (o_err) eq.push_back(cyc);
            if (prev_busy && !o_busy) busy_fall = cyc;
            prev_busy = o_busy;
        end
    end

    task automatic send(input logic [7:0] b, input logic stop,
                        input bit track, output int c);
        logic [9:0] bits;
        ev_t        ev;
        bits = {stop, b, 1'b0};
        @(posedge clk);
        #1;
        c = cyc;
        if (track) begin
            ev.at   = c + LAT;
            ev.err  = !stop;
            ev.data = b;
            evq.push_back(ev);
        end
        for (int i = 0; i < 10; i++) begin
            i_rx = bits[i];
            repeat (DIV - 1) @(posedge clk);
            if (i < 9) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic clear_mon();
        vq.delete();
        dq.delete();
        eq.delete();
    endtask

    initial begin
        int c0;
        int c1;
        int c2;
        logic [7:0] sweep[$];

        rst_n = 1'b0;
        i_rx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", 32'(o_data), 32'h00);
        chk("rst_vld", 32'(o_vld), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // Single byte: exact latency and busy drop.
        clear_mon();
        send(8'hA5, 1'b1, 1'b1, c0);
        repeat (20) @(posedge clk);
        chk("t1_count", 32'(vq.size()), 32'd1);
        if (vq.size() == 1) begin
            chk("t1_at", 32'(vq[0] - c0), 32'd240);
            chk("t1_data", 32'(dq[0]), 32'hA5);
        end
        chk("t1_busyfall", 32'(busy_fall - c0), 32'd240);
        chk("t1_noerr", 32'(eq.size()), 32'd0);

        // Back-to-back frames, no idle gap.
        clear_mon();
        send(8'h00, 1'b1, 1'b1, c0);
        send(8'hFF, 1'b1, 1'b1, c1);
        send(8'h55, 1'b1, 1'b1, c2);
        repeat (20) @(posedge clk);
        chk("t2_count", 32'(vq.size()), 32'd3);
        if (vq.size() == 3) begin
            chk("t2_first", 32'(vq[0] - c0), 32'd240);
            chk("t2_gap1", 32'(vq[1] - vq[0]), 32'd250);
            chk("t2_gap2", 32'(vq[2] - vq[1]), 32'd250);
            chk("t2_d0", 32'(dq[0]), 32'h00);
            chk("t2_d1", 32'(dq[1]), 32'hFF);
            chk("t2_d2", 32'(dq[2]), 32'h55);
        end

        // Short glitch is rejected, next frame still received.
        clear_mon();
        @(posedge clk);
        #1;
        i_rx = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        i_rx = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("t3_novld", 32'(vq.size()), 32'd0);
        chk("t3_noerr", 32'(eq.size()), 32'd0);
        chk("t3_idle", 32'(o_busy), 32'd0);
        send(8'h3C, 1'b1, 1'b1, c0);
        repeat (20) @(posedge clk);
        chk("t3_count", 32'(vq.size()), 32'd1);
        if (vq.size() == 1) chk("t3_data", 32'(dq[0]), 32'h3C);

        // Framing error, break, recovery.
        clear_mon();
        send(8'h81, 1'b0, 1'b1, c0);
        repeat (100) @(posedge clk);
        #1;
        chk("t4_break_busy", 32'(o_busy), 32'd1);
        chk("t4_err_count", 32'(eq.size()), 32'd1);
        if (eq.size() == 1) chk("t4_err_at", 32'(eq[0] - c0), 32'd240);
        chk("t4_held", 32'(o_data), 32'h3C);
        i_rx = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("t4_idle", 32'(o_busy), 32'd0);
        send(8'h3C, 1'b1, 1'b1, c0);
        repeat (20) @(posedge clk);
        chk("t4_vld_count", 32'(vq.size()), 32'd1);
        chk("t4_err_total", 32'(eq.size()), 32'd1);

        // Reset during data bit 4 abandons the frame silently.
        clear_mon();
        fork
            send(8'hFF, 1'b1, 1'b0, c0);
            begin
                repeat (136) @(posedge clk);
                #1;
                rst_n = 1'b0;
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                chk("t5_busy", 32'(o_busy), 32'd0);
                chk("t5_data", 32'(o_data), 32'h00);
                chk("t5_vld", 32'(o_vld), 32'd0);
            end
        join
        repeat (10) @(posedge clk);
        chk("t5_nopulse", 32'(vq.size() + eq.size()), 32'd0);
        send(8'h7E, 1'b1, 1'b1, c0);
        repeat (20) @(posedge clk);
        chk("t5_count", 32'(vq.size()), 32'd1);
        if (vq.size() == 1) chk("t5_after", 32'(dq[0]), 32'h7E);

        // Stream of varied bytes back-to-back.
        clear_mon();
        for (int i = 0; i < 64; i++) begin
            logic [7:0] b;
            b = 8'((i * 4) + (i >> 4));
            sweep.push_back(b);
            send(b, 1'b1, 1'b1, c0);
        end
        repeat (20) @(posedge clk);
        chk("t6_count", 32'(vq.size()), 32'd64);
        chk("t6_noerr", 32'(eq.size()), 32'd0);
        if (vq.size() == 64) begin
            for (int i = 0; i < 64; i++) begin
                chk("t6_data", 32'(dq[i]), 32'(sweep[i]));
            end
        end

        chk("model_drained", 32'(evq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
